// File: rtl/call_stack.sv
// Hardware return-address stack: CALL pushes, RTN pops, with the top entry
// presented combinationally for same-cycle jump targets. Overflow and
// underflow are latched as sticky faults and raised as a halt request.
module call_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             move_fp,
  input  logic             push_up,
  input  logic [WIDTH-1:0] push_data,
  input  logic [PTR_W-1:0] peek_idx,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top_data,
  output logic [WIDTH-1:0] peek_data,
  output logic [PTR_W:0]   depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             halt_req
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] peek_pos;
  logic             peek_ok;
  logic             push_req, pop_req;
  logic             do_push, do_pop;
  logic             ovf_set, unf_set;

  assign depth    = count;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign halt_req = overflow | underflow;

  // Low pointer bits wrap to DEPTH-1 when full, which is exactly the top slot.
  assign top_idx  = count[PTR_W-1:0] - PTR_W'(1);
  assign peek_pos = top_idx - peek_idx;
  assign peek_ok  = ({1'b0, peek_idx} < count);

  assign top_data  = empty   ? '0 : mem[top_idx];
  assign peek_data = peek_ok ? mem[peek_pos] : '0;

  assign push_req = en & move_fp & ~push_up;
  assign pop_req  = en & move_fp &  push_up;

  // Fault events are evaluated even while halted; data movement is not.
  assign ovf_set = push_req & full;
  assign unf_set = pop_req  & empty;
  assign do_push = push_req & ~full  & ~halt_req;
  assign do_pop  = pop_req  & ~empty & ~halt_req;

  // Storage array: write the slot just above the current top on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[count[PTR_W-1:0]] <= push_data;
    end
  end

  // Entry count, saturating at 0 and DEPTH by construction of do_push/do_pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       count <= '0;
    else if (do_push) count <= count + (PTR_W+1)'(1);
    else if (do_pop)  count <= count - (PTR_W+1)'(1);
  end

  // Sticky fault flags; a new fault wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow  <= 1'b1;
      else if (err_clr) overflow  <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Directed table-driven bench for call_stack plus hand-written sequences
// for overflow, halt freeze and asynchronous mid-sequence reset.
module tb_call_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, move_fp, push_up, err_clr;
  logic [WIDTH-1:0] push_data;
  logic [PTR_W-1:0] peek_idx;
  logic [WIDTH-1:0] top_data, peek_data;
  logic [PTR_W:0]   depth;
  logic             empty, full, overflow, underflow, halt_req;

  int checks = 0;
  int errors = 0;

  call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .move_fp(move_fp), .push_up(push_up),
    .push_data(push_data), .peek_idx(peek_idx), .err_clr(err_clr),
    .top_data(top_data), .peek_data(peek_data), .depth(depth), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow), .halt_req(halt_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, mv, up, clr;
    logic [15:0] data;
    logic [3:0]  pk;
    logic [15:0] exp_pre_top;
    logic [4:0]  exp_depth;
    logic [15:0] exp_top;
    logic [15:0] exp_peek;
    logic        exp_ovf, exp_unf;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic e, logic m, logic u, logic c, logic [15:0] d,
                              logic [3:0] p, logic [15:0] pre, logic [4:0] dp,
                              logic [15:0] t, logic [15:0] pd, logic o, logic un);
    vec_t v;
    v.en = e; v.mv = m; v.up = u; v.clr = c; v.data = d; v.pk = p;
    v.exp_pre_top = pre; v.exp_depth = dp; v.exp_top = t; v.exp_peek = pd;
    v.exp_ovf = o; v.exp_unf = un;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic m, input logic u, input logic c,
                       input logic [15:0] d, input logic [3:0] p);
    en = e; move_fp = m; push_up = u; err_clr = c; push_data = d; peek_idx = p;
  endtask

  task automatic chk_post(input string tag, input logic [4:0] dp, input logic [15:0] t,
                          input logic o, input logic un);
    chk({tag, ".depth"}, 32'(depth), 32'(dp));
    chk({tag, ".top"}, 32'(top_data), 32'(t));
    chk({tag, ".empty"}, 32'(empty), 32'(dp == 5'd0));
    chk({tag, ".full"}, 32'(full), 32'(dp == 5'd16));
    chk({tag, ".ovf"}, 32'(overflow), 32'(o));
    chk({tag, ".unf"}, 32'(underflow), 32'(un));
    chk({tag, ".halt"}, 32'(halt_req), 32'(o | un));
  endtask

  // One cycle: drive at negedge, check same-cycle top, clock, check post-edge state.
  task automatic step(input string tag, input logic e, input logic m, input logic u,
                      input logic c, input logic [15:0] d, input logic [15:0] pre,
                      input logic [4:0] dp, input logic [15:0] t, input logic o,
                      input logic un);
    @(negedge clk);
    drive(e, m, u, c, d, 4'd0);
    #1 chk({tag, ".pre_top"}, 32'(top_data), 32'(pre));
    @(posedge clk);
    #1 chk_post(tag, dp, t, o, un);
  endtask

  initial begin
    vecs[0]  = mk(1,1,0,0,16'h0010,0, 16'h0000, 1, 16'h0010, 16'h0010, 0,0);
    vecs[1]  = mk(1,1,0,0,16'h0020,0, 16'h0010, 2, 16'h0020, 16'h0020, 0,0);
    vecs[2]  = mk(1,1,0,0,16'h0030,2, 16'h0020, 3, 16'h0030, 16'h0010, 0,0);
    vecs[3]  = mk(1,1,1,0,16'h0000,1, 16'h0030, 2, 16'h0020, 16'h0010, 0,0);
    vecs[4]  = mk(1,1,1,0,16'h0000,0, 16'h0020, 1, 16'h0010, 16'h0010, 0,0);
    vecs[5]  = mk(1,1,1,0,16'h0000,0, 16'h0010, 0, 16'h0000, 16'h0000, 0,0);
    vecs[6]  = mk(1,1,1,0,16'h0000,0, 16'h0000, 0, 16'h0000, 16'h0000, 0,1);
    vecs[7]  = mk(1,1,1,1,16'h0000,0, 16'h0000, 0, 16'h0000, 16'h0000, 0,1);
    vecs[8]  = mk(1,0,0,1,16'h0000,0, 16'h0000, 0, 16'h0000, 16'h0000, 0,0);
    vecs[9]  = mk(1,1,0,0,16'hAAAA,0, 16'h0000, 1, 16'hAAAA, 16'hAAAA, 0,0);
    vecs[10] = mk(1,1,0,0,16'hBBBB,1, 16'hAAAA, 2, 16'hBBBB, 16'hAAAA, 0,0);
    vecs[11] = mk(0,1,0,0,16'hCCCC,2, 16'hBBBB, 2, 16'hBBBB, 16'h0000, 0,0);
    vecs[12] = mk(1,1,1,0,16'h0000,0, 16'hBBBB, 1, 16'hAAAA, 16'hAAAA, 0,0);
    vecs[13] = mk(1,1,1,0,16'h0000,0, 16'hAAAA, 0, 16'h0000, 16'h0000, 0,0);
    vecs[14] = mk(0,1,1,0,16'h0000,0, 16'h0000, 0, 16'h0000, 16'h0000, 0,0);
    vecs[15] = mk(1,1,1,0,16'h0000,0, 16'h0000, 0, 16'h0000, 16'h0000, 0,1);
    vecs[16] = mk(0,1,1,1,16'h0000,0, 16'h0000, 0, 16'h0000, 16'h0000, 0,0);

    // Reset held for two cycles.
    drive(0, 0, 0, 0, 16'h0, 4'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_post("rst_hold", 5'd0, 16'h0, 1'b0, 1'b0);
    chk("rst_hold.peek", 32'(peek_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_post("rst_rel", 5'd0, 16'h0, 1'b0, 1'b0);

    // Table: nested calls, underflow with set-wins, stall/peek, clear under en=0.
    for (int i = 0; i < 17; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(vecs[i].en, vecs[i].mv, vecs[i].up, vecs[i].clr, vecs[i].data, vecs[i].pk);
      #1 chk({tag, ".pre_top"}, 32'(top_data), 32'(vecs[i].exp_pre_top));
      @(posedge clk);
      #1 chk_post(tag, vecs[i].exp_depth, vecs[i].exp_top, vecs[i].exp_ovf, vecs[i].exp_unf);
      chk({tag, ".peek"}, 32'(peek_data), 32'(vecs[i].exp_peek));
    end

    // Fill to full.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1, 1, 0, 0, 16'h1000 + 16'(i), 4'd0);
      @(posedge clk);
    end
    #1 chk_post("fill", 5'd16, 16'h100F, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 0, 0, 0, 16'h0, 4'd15);
    #1 chk("fill.peek_bottom", 32'(peek_data), 32'h1000);

    // Overflow, frozen pop while halted, clear, then unwind.
    step("ovf_push", 1,1,0,0, 16'h2000, 16'h100F, 5'd16, 16'h100F, 1'b1, 1'b0);
    step("halt_pop", 1,1,1,0, 16'h0000, 16'h100F, 5'd16, 16'h100F, 1'b1, 1'b0);
    step("ovf_clr",  1,0,0,1, 16'h0000, 16'h100F, 5'd16, 16'h100F, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) begin
      step($sformatf("unwind%0d", i), 1,1,1,0, 16'h0, 16'h1000 + 16'(i), 5'(i),
           (i == 0) ? 16'h0 : 16'h1000 + 16'(i - 1), 1'b0, 1'b0);
    end

    // Five pushes, then an asynchronous reset pulse between edges.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 1, 0, 0, 16'h0500 + 16'(i), 4'd0);
      @(posedge clk);
    end
    #1 chk("pre_rst.depth", 32'(depth), 32'd5);
    @(negedge clk);
    drive(0, 0, 0, 0, 16'h0, 4'd0);
    #1 rst_n = 1'b0;
    #1 chk_post("async_rst", 5'd0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("post_rst", 1,1,0,0, 16'h0042, 16'h0000, 5'd1, 16'h0042, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
